// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute stage (ALU decode, 32-bit ALU with zero flag, PC+4 and PC+imm adders).
// Optional ALU_OVERFLOW_EN builds the registered signed-overflow flag for ADD/SUB.
module alu_exec_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [2:0]  alu_op,
   input  logic [2:0]  funct3,
   input  logic        alu_src,
   input  logic [31:0] read_data1,
   input  logic [31:0] read_data2,
   input  logic [31:0] immediate,
   input  logic [31:0] pc,
   output logic        out_valid,
   output logic [3:0]  alu_control,
   output logic [31:0] alu_result,
   output logic        zero,
   output logic        overflow,
   output logic [31:0] pc_plus4,
   output logic [31:0] branch_target
);
   localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0110,
                          C_SLT = 4'b0111, C_SLTU = 4'b1000, C_XOR = 4'b1001, C_SLL = 4'b1010,
                          C_SRL = 4'b1011, C_SRA = 4'b1100, C_PASSB = 4'b1101;
   logic [31:0] a, b, res;
   logic [4:0]  sh;
   logic [3:0]  rcode, bcode, code;
   assign a  = read_data1;
   assign b  = alu_src ? immediate : read_data2;
   assign sh = b[4:0];
   always_comb begin
      rcode = C_ADD;
      case (funct3)
         3'b001: rcode = C_SLL;
         3'b010: rcode = C_SLT;
         3'b011: rcode = C_SLTU;
         3'b100: rcode = C_XOR;
         3'b101: rcode = C_SRL;
         3'b110: rcode = C_OR;
         3'b111: rcode = C_AND;
         default: rcode = C_ADD;
      endcase
   end
   assign bcode = funct3[2:1] == 2'b10 ? C_SLT : funct3[2:1] == 2'b11 ? C_SLTU : C_SUB;
   assign code  = alu_op == 3'b001 ? bcode :
                  (alu_op == 3'b010 || alu_op == 3'b011) ? rcode :
                  alu_op == 3'b100 ? (funct3 == 3'b000 ? C_SUB : funct3 == 3'b101 ? C_SRA : rcode) :
                  alu_op == 3'b101 ? C_PASSB : C_ADD;
   always_comb begin
      res = '0;
      case (code)
         C_AND:   res = a & b;
         C_OR:    res = a | b;
         C_ADD:   res = a + b;
         C_SUB:   res = a - b;
         C_SLT:   res = $signed(a) < $signed(b) ? 32'd1 : 32'd0;
         C_SLTU:  res = a < b ? 32'd1 : 32'd0;
         C_XOR:   res = a ^ b;
         C_SLL:   res = a << sh;
         C_SRL:   res = a >> sh;
         C_SRA:   res = $signed(a) >>> sh;
         C_PASSB: res = b;
         default: res = '0;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid     <= 1'b0;
         alu_control   <= '0;
         alu_result    <= '0;
         zero          <= 1'b0;
         pc_plus4      <= '0;
         branch_target <= '0;
      end else begin
         out_valid     <= in_valid;
         alu_control   <= code;
         alu_result    <= res;
         zero          <= res == 32'd0;
         pc_plus4      <= pc + 32'h4;
         branch_target <= pc + immediate;
      end
   end
`ifdef ALU_OVERFLOW_EN
   // SUB overflows when operand signs differ and the result sign leaves A's sign
   logic ov_next;
   assign ov_next = (code == C_ADD && a[31] == b[31] && res[31] != a[31]) ||
                    (code == C_SUB && a[31] != b[31] && res[31] != a[31]);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) overflow <= 1'b0;
      else overflow <= ov_next;
   end
`else
   assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against a behavioural model.
module tb_alu_exec_unit;
   localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0110,
                          C_SLT = 4'b0111, C_SLTU = 4'b1000, C_XOR = 4'b1001, C_SLL = 4'b1010,
                          C_SRL = 4'b1011, C_SRA = 4'b1100, C_PASSB = 4'b1101;
   logic        clk = 0, reset = 0, in_valid = 0, alu_src = 0;
   logic [2:0]  alu_op = 0, funct3 = 0;
   logic [31:0] read_data1 = 0, read_data2 = 0, immediate = 0, pc = 0;
   logic        out_valid, zero, overflow;
   logic [3:0]  alu_control;
   logic [31:0] alu_result, pc_plus4, branch_target;
   int checks = 0, failures = 0;
   logic [3:0] rtab [8];
   alu_exec_unit dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .alu_op(alu_op), .funct3(funct3),
      .alu_src(alu_src), .read_data1(read_data1), .read_data2(read_data2),
      .immediate(immediate), .pc(pc), .out_valid(out_valid), .alu_control(alu_control),
      .alu_result(alu_result), .zero(zero), .overflow(overflow), .pc_plus4(pc_plus4),
      .branch_target(branch_target)
   );
   always #5 clk = ~clk;
   function automatic logic [3:0] ref_code(input logic [2:0] op, input logic [2:0] f3);
      if (op == 3'd1) return f3 >= 3'd6 ? C_SLTU : f3 >= 3'd4 ? C_SLT : C_SUB;
      if (op == 3'd2 || op == 3'd3) return rtab[f3];
      if (op == 3'd4) return f3 == 3'd0 ? C_SUB : f3 == 3'd5 ? C_SRA : rtab[f3];
      if (op == 3'd5) return C_PASSB;
      return C_ADD;
   endfunction
   function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
      longint sx = longint'($signed(x)), sy = longint'($signed(y));
      int unsigned s = y % 32;
      case (c)
         C_AND:   return x & y;
         C_OR:    return x | y;
         C_ADD:   return 32'(sx + sy);
         C_SUB:   return 32'(sx - sy);
         C_SLT:   return sx < sy ? 32'd1 : 32'd0;
         C_SLTU:  return x < y ? 32'd1 : 32'd0;
         C_XOR:   return x ^ y;
         C_SLL:   return 32'(64'(x) * (64'd1 << s));
         C_SRL:   return x / (32'd1 << s);
         C_SRA:   return 32'(sx >>> s);
         C_PASSB: return y;
         default: return 32'd0;
      endcase
   endfunction
   function automatic logic ref_ov(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
`ifdef ALU_OVERFLOW_EN
      longint sx = longint'($signed(x)), sy = longint'($signed(y)), r;
      if (c != C_ADD && c != C_SUB) return 1'b0;
      r = c == C_ADD ? sx + sy : sx - sy;
      return r > 64'sd2147483647 || r < -64'sd2147483648;
`else
      return 1'b0;
`endif
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   task automatic check_zero_outputs(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_ctrl"}, 32'(alu_control), 32'd0);
      chk({tag, "_res"}, alu_result, 32'd0);
      chk({tag, "_zero"}, 32'(zero), 32'd0);
      chk({tag, "_ov"}, 32'(overflow), 32'd0);
      chk({tag, "_pc4"}, pc_plus4, 32'd0);
      chk({tag, "_bt"}, branch_target, 32'd0);
   endtask
   task automatic step(input string tag, input logic [2:0] op, input logic [2:0] f3, input logic src,
                       input logic [31:0] a, input logic [31:0] rd2, input logic [31:0] imm,
                       input logic [31:0] p, input logic v);
      logic [3:0]  c;
      logic [31:0] bb, r;
      @(negedge clk);
      alu_op = op; funct3 = f3; alu_src = src; read_data1 = a; read_data2 = rd2;
      immediate = imm; pc = p; in_valid = v;
      bb = src ? imm : rd2;
      c  = ref_code(op, f3);
      r  = ref_res(c, a, bb);
      @(posedge clk); #1;
      chk({tag, "_valid"}, 32'(out_valid), 32'(v));
      chk({tag, "_ctrl"}, 32'(alu_control), 32'(c));
      chk({tag, "_res"}, alu_result, r);
      chk({tag, "_zero"}, 32'(zero), 32'(r == 0));
      chk({tag, "_ov"}, 32'(overflow), 32'(ref_ov(c, a, bb)));
      chk({tag, "_pc4"}, pc_plus4, p + 32'd4);
      chk({tag, "_bt"}, branch_target, p + imm);
   endtask
   initial begin
      rtab = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_OR, C_AND};
      repeat (2) @(posedge clk);
      #1 check_zero_outputs("rst_init");
      @(negedge clk) reset = 1;
      step("pre", 3'd2, 3'd6, 1'b0, 32'hA5A5_0000, 32'h0000_5A5A, 32'h40, 32'h2000, 1'b1);
      // assert reset between edges: outputs must clear without a clock
      @(negedge clk);
      in_valid = 1; alu_op = 3'd0; read_data1 = 32'd9; immediate = 32'd1; alu_src = 1;
      #2 reset = 0;
      #1 check_zero_outputs("rst_async");
      @(posedge clk); #1 check_zero_outputs("rst_hold");
      @(negedge clk) reset = 1;
      step("ld_add", 3'd0, 3'd0, 1'b1, 32'd5, 32'd0, 32'd7, 32'h0, 1'b1);
      chk("ld_add_lit", alu_result, 32'd12);
      step("beq_eq", 3'd1, 3'd0, 1'b0, 32'h1234, 32'h1234, 32'h8, 32'h40, 1'b1);
      chk("beq_zero_lit", 32'(zero), 32'd1);
      step("beq_ne", 3'd1, 3'd0, 1'b0, 32'd1, 32'd2, 32'h8, 32'h40, 1'b1);
      step("sll", 3'd2, 3'd1, 1'b0, 32'hF000_0000, 32'd4, 32'd0, 32'h80, 1'b1);
      step("srl", 3'd2, 3'd5, 1'b0, 32'hF000_0000, 32'd4, 32'd0, 32'h80, 1'b1);
      chk("srl_lit", alu_result, 32'h0F00_0000);
      step("slt", 3'd2, 3'd2, 1'b0, 32'hF000_0000, 32'd4, 32'd0, 32'h80, 1'b1);
      step("sltu", 3'd2, 3'd3, 1'b0, 32'hF000_0000, 32'd4, 32'd0, 32'h80, 1'b1);
      step("sra", 3'd4, 3'd5, 1'b0, 32'hF000_0000, 32'd4, 32'd0, 32'h80, 1'b1);
      chk("sra_lit", alu_result, 32'hFF00_0000);
      step("adders", 3'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h100, 1'b1);
      chk("bt_lit", branch_target, 32'h0000_00F0);
      step("pc_wrap", 3'd0, 3'd0, 1'b0, 32'd3, 32'd4, 32'd0, 32'hFFFF_FFFC, 1'b0);
      chk("pc_wrap_lit", pc_plus4, 32'd0);
      step("lui", 3'd5, 3'd3, 1'b1, 32'hDEAD_BEEF, 32'd0, 32'h1234_5000, 32'h10, 1'b1);
      chk("lui_lit", alu_result, 32'h1234_5000);
      step("ovf_add", 3'd0, 3'd0, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h0, 1'b1);
      chk("ovf_add_lit", alu_result, 32'h8000_0000);
      step("ovf_sub", 3'd4, 3'd0, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 32'h0, 1'b1);
      step("op110", 3'd6, 3'd7, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h4, 1'b1);
      for (int i = 0; i < 300; i++) begin
         logic [31:0] ra, rb, ri;
         ra = $urandom; rb = $urandom; ri = $urandom;
         if ($urandom_range(0, 3) == 0) ra = 32'h7FFF_FFFF + 32'($urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) rb = ra;
         step("rnd", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom),
              ra, rb, ri, $urandom, 1'($urandom));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execute-stage unit of the single-issue RISC-V datapath. It combines three functions behind one output register: ALU operation decode from ALUOp/funct3, the 32-bit ALU with its zero flag, and the two PC adders (PC+4 and PC+immediate). It sits between the register file/immediate generator and the data memory/PC-select logic.

## Interface
- No parameters; data width fixed at 32 bits.
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands on inputs are valid this cycle.
- alu_op  in  3  ALU operation class from main control.
- funct3  in  3  instruction bits [14:12].
- alu_src  in  1  0: operand B = read_data2; 1: operand B = immediate.
- read_data1  in  32  operand A (rs1).
- read_data2  in  32  rs2 value.
- immediate  in  32  sign-extended immediate.
- pc  in  32  current PC.
- out_valid  out  1  registered in_valid.
- alu_control  out  4  registered decoded ALU control code.
- alu_result  out  32  registered ALU result.
- zero  out  1  registered (alu_result == 0).
- overflow  out  1  registered signed overflow of ADD/SUB (see Configuration).
- pc_plus4  out  32  registered pc + 4.
- branch_target  out  32  registered pc + immediate.

## Operation
- Operand B = alu_src ? immediate : read_data2.
- Decode (alu_op -> code):
  - 000 (load/store): ADD.
  - 001 (branch): funct3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> SUB.
  - 010 (R-type) and 011 (I-type arith): funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - 100 (R-type alternate): funct3 000 SUB, 101 SRA, others as 010.
  - 101 (LUI): PASSB.
  - 110, 111: ADD.
- Codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLTU 1000, XOR 1001, SLL 1010, SRL 1011, SRA 1100, PASSB 1101; any other code yields result 0.
- Arithmetic mod 2^32, carries discarded. SLT signed and SLTU unsigned compares give 32'd1 or 32'd0. Shift amount = B[4:0]; SRA replicates A[31].
- zero = 1 iff the 32-bit result is 0, for every operation.
- Adders: pc_plus4 = pc + 32'h4; branch_target = pc + immediate; both wrap mod 2^32 (pc = 32'hFFFFFFFC gives pc_plus4 = 0).
- All outputs are captured every rising edge regardless of in_valid; out_valid qualifies them.

## Timing
- Latency exactly 1 cycle: inputs sampled at edge N appear on outputs after edge N; throughput one operation per cycle, no stalls, no backpressure.
- Reset asserted (low): all outputs, including out_valid and zero, go to 0 immediately, without waiting for a clock edge; they hold 0 while reset is low.
- Reset deasserted: the first capture occurs at the first rising edge after release. An operation in flight when reset asserts is discarded.
- No combinational path from inputs to outputs.

## Configuration
- ALU_OVERFLOW_EN defined: overflow is registered as the signed overflow of ADD (operands with equal signs, result sign differs) or SUB (operands with different signs, result sign differs from A); it is 0 for all other codes.
- ALU_OVERFLOW_EN undefined: overflow is constant 0 and no overflow logic is built.

## Test plan
- Reset: drive reset low mid-operation -> all outputs 0 asynchronously. Release, apply alu_op=000, A=5, immediate=7, alu_src=1 -> after one edge alu_result=12, alu_control=0010, out_valid=1.
- Branch equal: alu_op=001, funct3=000, A=B=32'h1234 -> alu_result=0, zero=1, alu_control=0110. A=1, B=2 -> zero=0.
- R-type sweep: A=32'hF0000000, B=4, alu_op=010, funct3 = 001/101/010/011 -> SLL 0, SRL 32'h0F000000, SLT 1, SLTU 0. Then alu_op=100, funct3=101 -> SRA 32'hFF000000.
- Adders: pc=32'h100, immediate=32'hFFFFFFF0 -> pc_plus4=32'h104, branch_target=32'hF0. pc=32'hFFFFFFFC -> pc_plus4=0.
- LUI/default: alu_op=101, immediate=32'h12345000, alu_src=1 -> alu_result=32'h12345000, zero=0.
- Overflow: ADD with A=32'h7FFFFFFF, B=1 -> result 32'h80000000; overflow=1 with ALU_OVERFLOW_EN defined, 0 without it.
